// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU between two requesters.
// Round-robin grant in IDLE, one cycle of ALU evaluation in EXEC, and the
// captured result is held in RESP until the consumer takes it.
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] EXEC = 2'b01;
  localparam logic [1:0] RESP = 2'b10;

  logic [1:0] state;
  logic       prio;
  logic       cur_id;
  logic       grant;
  logic       any_valid;

  // Op codes the ALU implements; anything else is reported as an error.
  function automatic logic ctrl_legal(input logic [2:0] c);
    case (c)
      3'b000, 3'b001, 3'b010, 3'b011, 3'b101: ctrl_legal = 1'b1;
      default:                                ctrl_legal = 1'b0;
    endcase
  endfunction

  // Grant selection: a lone requester always wins, contention goes to prio.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant = prio;
    end else if (req1_valid) begin
      grant = 1'b1;
    end else begin
      grant = 1'b0;
    end
  end

  // Ready is only offered in IDLE, and only to the granted requester.
  always_comb begin
    if (state == IDLE) begin
      req0_ready = req0_valid & ~grant;
      req1_ready = req1_valid & grant;
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

  // Main sequencer: accept, evaluate for one cycle, then hold the response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      prio       <= 1'b0;
      cur_id     <= 1'b0;
      alu_a      <= {WIDTH{1'b0}};
      alu_b      <= {WIDTH{1'b0}};
      alu_ctrl   <= 3'b000;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= {WIDTH{1'b0}};
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            alu_a    <= grant ? req1_a : req0_a;
            alu_b    <= grant ? req1_b : req0_b;
            alu_ctrl <= grant ? req1_ctrl : req0_ctrl;
            cur_id   <= grant;
            prio     <= ~grant;
            busy     <= 1'b1;
            state    <= EXEC;
          end else begin
            state    <= IDLE;
          end
        end
        EXEC: begin
          rsp_id    <= cur_id;
          rsp_valid <= 1'b1;
          if (ctrl_legal(alu_ctrl)) begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
            rsp_err    <= 1'b0;
          end else begin
            // Whatever the ALU produced for an illegal op is discarded.
            rsp_result <= {WIDTH{1'b0}};
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            state     <= RESP;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed stimulus with a response scoreboard.
module tb_alu_share_arbiter;

  typedef struct packed {
    logic        id;
    logic [31:0] result;
    logic        zero;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_ctrl, req1_ctrl;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_ctrl;
  logic        alu_zero;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err, busy;
  logic [31:0] rsp_result;

  int   errors = 0;
  int   checks = 0;
  rsp_t exp_q[$];
  logic grants[$];

  alu_share_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in ALU; illegal codes produce garbage so the arbiter must mask it.
  always_comb begin
    case (alu_ctrl)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b101:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_result = 32'hDEAD_BEEF;
    endcase
    alu_zero = (alu_ctrl == 3'b100 || alu_ctrl == 3'b110 || alu_ctrl == 3'b111) ? 1'b1
             : (alu_result == 32'd0);
  end

  function automatic rsp_t expect_rsp(input logic id, input logic [2:0] c,
                                      input logic [31:0] a, input logic [31:0] b);
    rsp_t r;
    r.id  = id;
    r.err = 1'b0;
    case (c)
      3'b000:  r.result = a + b;
      3'b001:  r.result = a - b;
      3'b010:  r.result = a & b;
      3'b011:  r.result = a | b;
      3'b101:  r.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: begin r.result = 32'd0; r.err = 1'b1; end
    endcase
    r.zero = !r.err && (r.result == 32'd0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 30) begin
      cyc();
      n++;
    end
    chk(tag, {31'd0, n < 30}, 32'd1);
  endtask

  // Scoreboard monitor: sampled mid-cycle, so it sees what the next edge will act on.
  always @(negedge clk) begin
    if (!reset) begin
      if (req0_ready && req1_ready) chk("two_readys", 32'd1, 32'd0);
      if (req0_ready) begin
        exp_q.push_back(expect_rsp(1'b0, req0_ctrl, req0_a, req0_b));
        grants.push_back(1'b0);
      end
      if (req1_ready) begin
        exp_q.push_back(expect_rsp(1'b1, req1_ctrl, req1_a, req1_b));
        grants.push_back(1'b1);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          chk("sb_id", {31'd0, rsp_id}, {31'd0, e.id});
          chk("sb_result", rsp_result, e.result);
          chk("sb_zero", {31'd0, rsp_zero}, {31'd0, e.zero});
          chk("sb_err", {31'd0, rsp_err}, {31'd0, e.err});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req0_a = 32'd0; req0_b = 32'd0; req0_ctrl = 3'b000;
    req1_valid = 1'b0; req1_a = 32'd0; req1_b = 32'd0; req1_ctrl = 3'b000;
    rsp_ready = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;

    // Reset state with nothing requested.
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_readys", {30'd0, req1_ready, req0_ready}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      chk("rst_alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
    end

    // Lone req0 ADD 10,5.
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd5; req0_ctrl = 3'b000;
    #1;
    chk("add_ready0", {31'd0, req0_ready}, 32'd1);
    chk("add_ready1", {31'd0, req1_ready}, 32'd0);
    cyc();
    req0_valid = 1'b0;
    #1;
    chk("add_exec_busy", {31'd0, busy}, 32'd1);
    chk("add_exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("add_exec_ready0", {31'd0, req0_ready}, 32'd0);
    chk("add_alu_a", alu_a, 32'd10);
    chk("add_alu_b", alu_b, 32'd5);
    cyc();
    chk("add_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("add_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("add_rsp_result", rsp_result, 32'd15);
    chk("add_rsp_zero", {31'd0, rsp_zero}, 32'd0);
    chk("add_rsp_err", {31'd0, rsp_err}, 32'd0);
    cyc();
    chk("add_done_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("add_done_busy", {31'd0, busy}, 32'd0);
    chk("add_alu_hold", alu_a, 32'd10);

    // Continuous contention from a fresh reset: grants must alternate.
    do_reset();
    grants.delete();
    req0_valid = 1'b1; req0_a = 32'd20; req0_b = 32'd20; req0_ctrl = 3'b001;
    req1_valid = 1'b1; req1_a = 32'd5;  req1_b = 32'd10; req1_ctrl = 3'b101;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (grants.size() >= 4) break;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("rr_grant_count", grants.size(), 32'd4);
    for (int i = 0; i < grants.size() && i < 4; i++) begin
      logic [31:0] iv;
      iv = i;
      chk("rr_grant_order", {31'd0, grants[i]}, {31'd0, iv[0]});
    end
    wait_idle("rr_drain");

    // Illegal op from req1.
    req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd9; req1_ctrl = 3'b111;
    #1;
    chk("ill_ready1", {31'd0, req1_ready}, 32'd1);
    cyc();
    req1_valid = 1'b0;
    cyc();
    chk("ill_rsp_err", {31'd0, rsp_err}, 32'd1);
    chk("ill_rsp_result", rsp_result, 32'd0);
    chk("ill_rsp_zero", {31'd0, rsp_zero}, 32'd0);
    chk("ill_rsp_id", {31'd0, rsp_id}, 32'd1);
    wait_idle("ill_drain");

    // Backpressure in RESP with a competing requester waiting.
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h0000_00F0; req0_b = 32'h0000_003C; req0_ctrl = 3'b010;
    cyc();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_ctrl = 3'b000;
    begin
      int n = 0;
      while (!rsp_valid && n < 10) begin
        cyc();
        n++;
      end
      chk("bp_rsp_seen", {31'd0, rsp_valid}, 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rsp_result", rsp_result, 32'h0000_0030);
      chk("bp_rsp_id", {31'd0, rsp_id}, 32'd0);
      chk("bp_busy", {31'd0, busy}, 32'd1);
      chk("bp_readys", {30'd0, req1_ready, req0_ready}, 32'd0);
      cyc();
    end
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    cyc();
    chk("bp_release_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_release_busy", {31'd0, busy}, 32'd0);
    chk("bp_release_sb", exp_q.size(), 32'd0);

    // Reset while req0 OR 1,2 is in EXEC.
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_ctrl = 3'b011;
    cyc();
    req0_valid = 1'b0;
    chk("mid_exec_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_alu_a", alu_a, 32'd0);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    end
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_ctrl = 3'b000;
    #1;
    chk("post_rst_ready1", {31'd0, req1_ready}, 32'd1);
    chk("post_rst_ready0", {31'd0, req0_ready}, 32'd0);
    cyc();
    req1_valid = 1'b0;
    cyc();
    chk("post_rst_rsp_id", {31'd0, rsp_id}, 32'd1);
    chk("post_rst_rsp_result", rsp_result, 32'd7);
    wait_idle("post_rst_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
